// File: rtl/ram_32x8_sync.sv
// Single-port 32x8 synchronous RAM backing the L1 cache.
// Address is registered; q reads combinationally from the registered address (write-first).
module ram_32x8_sync #(
    parameter int                    ADDR_WIDTH = 5,
    parameter int                    DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = 8'h00
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  wren,
    output logic [DATA_WIDTH-1:0] q
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] addr_q;

    // Reset clears every word and takes priority over a write on the same edge.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= INIT_VALUE;
            end
            addr_q <= '0;
        end else begin
            addr_q <= address;
            if (wren) begin
                mem[address] <= data;
            end
        end
    end

    // Reading the stored array through addr_q gives write-first behaviour for free.
    assign q = mem[addr_q];

endmodule

// File: tb/tb_ram_32x8_sync.sv
// Self-checking bench for ram_32x8_sync: directed vector table, corner sequences,
// and randomized traffic compared against a simple array model of the memory.
module tb_ram_32x8_sync;

    logic       clock;
    logic       reset_n;
    logic [4:0] address;
    logic [7:0] data;
    logic       wren;
    logic [7:0] q;

    int n_compared;
    int n_mismatched;

    // Reference model: plain array of words plus the last addressed location.
    logic [7:0] model_mem [32];
    logic [4:0] model_addr;

    typedef struct {
        string      name;
        logic       rst_n;
        logic       we;
        logic [4:0] addr;
        logic [7:0] dat;
        logic [7:0] exp_q;
    } vec_t;

    vec_t vecs[$];

    ram_32x8_sync dut (
        .clock   (clock),
        .reset_n (reset_n),
        .address (address),
        .data    (data),
        .wren    (wren),
        .q       (q)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Drive inputs on the falling edge, take the rising edge, and settle before sampling.
    task automatic applyStimulus(input logic rst_n, input logic we,
                                 input logic [4:0] addr, input logic [7:0] dat);
        @(negedge clock);
        reset_n = rst_n;
        wren    = we;
        address = addr;
        data    = dat;
        @(posedge clock);
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) model_mem[i] = 8'h00;
            model_addr = 5'd0;
        end else begin
            model_addr = addr;
            if (we) model_mem[addr] = dat;
        end
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [7:0] expected);
        n_compared++;
        if (q !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: q=%h expected %h", name, q, expected);
        end
    endtask

    task automatic add_vec(input string name, input logic rst_n, input logic we,
                           input logic [4:0] addr, input logic [7:0] dat,
                           input logic [7:0] exp_q);
        vec_t v;
        v.name  = name;
        v.rst_n = rst_n;
        v.we    = we;
        v.addr  = addr;
        v.dat   = dat;
        v.exp_q = exp_q;
        vecs.push_back(v);
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        reset_n      = 1'b0;
        wren         = 1'b0;
        address      = 5'd0;
        data         = 8'h00;
        model_addr   = 5'd0;
        for (int i = 0; i < 32; i++) model_mem[i] = 8'h00;

        // Write/readback, write-first, neighbour-write and last-write-wins vectors.
        add_vec("wr_A5_at3",     1, 1,  3, 8'hA5, 8'hA5);
        add_vec("wr_5A_at17",    1, 1, 17, 8'h5A, 8'h5A);
        add_vec("wr_FF_at31",    1, 1, 31, 8'hFF, 8'hFF);
        add_vec("wr_01_at0",     1, 1,  0, 8'h01, 8'h01);
        add_vec("rd_3",          1, 0,  3, 8'h00, 8'hA5);
        add_vec("rd_17",         1, 0, 17, 8'h00, 8'h5A);
        add_vec("rd_31",         1, 0, 31, 8'h00, 8'hFF);
        add_vec("rd_0",          1, 0,  0, 8'h00, 8'h01);
        add_vec("rd_1_untouched",1, 0,  1, 8'hEE, 8'h00);
        add_vec("rd_30_untouched",1,0, 30, 8'h00, 8'h00);
        add_vec("wrfirst_3C_at9",1, 1,  9, 8'h3C, 8'h3C);
        add_vec("hold_9",        1, 0,  9, 8'h00, 8'h3C);
        add_vec("wr_11_at4",     1, 1,  4, 8'h11, 8'h11);
        add_vec("rd_4",          1, 0,  4, 8'h00, 8'h11);
        add_vec("wr_99_at5",     1, 1,  5, 8'h99, 8'h99);
        add_vec("rd_4_after_5",  1, 0,  4, 8'h00, 8'h11);
        add_vec("rd_5",          1, 0,  5, 8'h00, 8'h99);
        add_vec("wr_05_at2",     1, 1,  2, 8'h05, 8'h05);
        add_vec("wr_07_at2",     1, 1,  2, 8'h07, 8'h07);
        add_vec("rd_2_last_wins",1, 0,  2, 8'h00, 8'h07);
        add_vec("reset_drops_wr",0, 1, 12, 8'h77, 8'h00);
        add_vec("rd_12_cleared", 1, 0, 12, 8'h00, 8'h00);
        add_vec("rd_3_cleared",  1, 0,  3, 8'h00, 8'h00);
        add_vec("rd_9_cleared",  1, 0,  9, 8'h00, 8'h00);

        // Initial reset, then every word must read INIT_VALUE.
        applyStimulus(1'b0, 1'b1, 5'd7, 8'hAB);
        checkOutput("reset_q", 8'h00);
        for (int a = 0; a < 32; a++) begin
            applyStimulus(1'b1, 1'b0, 5'(a), 8'h00);
            checkOutput($sformatf("reset_word_%0d", a), 8'h00);
        end

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst_n, vecs[i].we, vecs[i].addr, vecs[i].dat);
            checkOutput(vecs[i].name, vecs[i].exp_q);
        end

        // Input activity between edges must not disturb q or the array.
        applyStimulus(1'b1, 1'b1, 5'd20, 8'h42);
        checkOutput("wr_42_at20", 8'h42);
        address = 5'd21;
        data    = 8'hEE;
        wren    = 1'b1;
        #2;
        checkOutput("between_edges_q", 8'h42);
        address = 5'd20;
        data    = 8'h13;
        #1;
        checkOutput("between_edges_q2", 8'h42);
        applyStimulus(1'b1, 1'b0, 5'd21, 8'h00);
        checkOutput("rd_21_no_glitch_wr", 8'h00);
        applyStimulus(1'b1, 1'b0, 5'd20, 8'h00);
        checkOutput("rd_20_intact", 8'h42);

        // Randomized traffic against the model, with occasional resets.
        for (int n = 0; n < 400; n++) begin
            logic       r_rst_n;
            logic       r_we;
            logic [4:0] r_addr;
            logic [7:0] r_dat;
            r_rst_n = ($urandom_range(0, 39) != 0);
            r_we    = 1'($urandom_range(0, 1));
            r_addr  = 5'($urandom);
            r_dat   = 8'($urandom);
            applyStimulus(r_rst_n, r_we, r_addr, r_dat);
            checkOutput($sformatf("rand_%0d", n), model_mem[model_addr]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
